cmul_rnd_sat_pipe: RTL and testbench

Parametrised pipelined complex multiplier with per-beat conjugate mode, round-half-up and saturation to a programmable output width, all inside a single block. Accepts paired AXI-Stream operands sharing one handshake and emits one rounded/clipped complex product per beat. Replaces the two-stage multiply-then-clip chain in DSP datapaths such as mixers, correlators and channel equalisers.

---
 rtl/cmul_rnd_sat_pkg.sv | 36 +++
 rtl/cmul_rnd_sat_pipe_rnd_sat_stage.sv | 57 +++++
 rtl/cmul_rnd_sat_pipe.sv | 165 ++++++++++++++++
 tb/tb_cmul_rnd_sat_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmul_rnd_sat_pkg.sv
// ============================================================================
// Module      : cmul_rnd_sat_pkg
// Description : Width helpers, operand packing indices and the saturation
//               range test shared by the complex multiplier blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmul_rnd_sat_pkg;

    // Half index of a packed complex word: I lives in the upper half.
    localparam int HALF_I = 1;
    localparam int HALF_Q = 0;

    function automatic int fw_f(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int drop_f(input int fw, input int ow, input int cb);
        return fw - ow - cb;
    endfunction

    function automatic int idx_lo_f(input int half, input int w);
        return half * w;
    endfunction

    // Saturate-to-N decision: {above max, below min} for an n-bit signed range.
    function automatic logic [1:0] sat_dir_f(input logic signed [63:0] x, input int n);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        return {x > hi, x < (-hi - 64'sd1)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmul_rnd_sat_pipe_rnd_sat_stage.sv
// ============================================================================
// Module      : rnd_sat_stage
// Description : One component round-half-up then signed saturation.
//               Clamp flag output exists only with CMUL_RND_SAT_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rnd_sat_stage
    import cmul_rnd_sat_pkg::*;
#(
    parameter int IN_WIDTH  = 33,
    parameter int OUT_WIDTH = 16,
    parameter int CLIP_BITS = 0
) (
    input  logic signed [IN_WIDTH-1:0]  x_i,
    output logic        [OUT_WIDTH-1:0] y_o
`ifdef CMUL_RND_SAT_FLAG_EN
    ,
    output logic                        sat_o
`endif
);

    localparam int DROP = drop_f(IN_WIDTH, OUT_WIDTH, CLIP_BITS);

    logic signed [63:0] ext_w;
    logic signed [63:0] rnd_w;
    logic        [1:0]  dir_w;

    assign ext_w = {{(64 - IN_WIDTH){x_i[IN_WIDTH-1]}}, x_i};

    generate
        if (DROP > 0) begin : g_round
            assign rnd_w = (ext_w + (64'sd1 <<< (DROP - 1))) >>> DROP;
        end else begin : g_pass
            assign rnd_w = ext_w;
        end
    endgenerate

    assign dir_w = sat_dir_f(rnd_w, OUT_WIDTH);

    always_comb begin
        y_o = rnd_w[OUT_WIDTH-1:0];
        if (dir_w[1]) begin
            y_o = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (dir_w[0]) begin
            y_o = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end
    end

`ifdef CMUL_RND_SAT_FLAG_EN
    assign sat_o = |dir_w;
`endif

endmodule

`default_nettype wire

// File: rtl/cmul_rnd_sat_pipe.sv
// ============================================================================
// Module      : cmul_rnd_sat_pipe
// Description : 4-stage AXI-Stream complex multiplier (a*b or a*conj(b)) with
//               round-half-up and saturation. CMUL_RND_SAT_FLAG_EN adds
//               out_tsat and sat_sticky.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmul_rnd_sat_pipe
    import cmul_rnd_sat_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int CLIP_BITS  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic                    in_tlast,
    input  logic                    in_tconj,
    input  logic [2*DATA_WIDTH-1:0] adata,
    input  logic [2*DATA_WIDTH-1:0] bdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic                    out_tlast,
    output logic [2*OUT_WIDTH-1:0]  pdata
`ifdef CMUL_RND_SAT_FLAG_EN
    ,
    output logic                    out_tsat,
    output logic                    sat_sticky
`endif
);

    localparam int FW     = fw_f(DATA_WIDTH);
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int A_I_LO = idx_lo_f(HALF_I, DATA_WIDTH);
    localparam int A_Q_LO = idx_lo_f(HALF_Q, DATA_WIDTH);
    localparam int P_I_LO = idx_lo_f(HALF_I, OUT_WIDTH);
    localparam int P_Q_LO = idx_lo_f(HALF_Q, OUT_WIDTH);

    logic                         adv;
    logic                         s1_v_q, s1_last_q, s1_conj_q;
    logic signed [DATA_WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
    logic                         s2_v_q, s2_last_q, s2_conj_q;
    logic signed [PW-1:0]         rr_q, ii_q, ri_q, ir_q;
    logic signed [FW-1:0]         rr_x, ii_x, ri_x, ir_x;
    logic                         s3_v_q, s3_last_q;
    logic signed [FW-1:0]         i_q, q_q, i_d, q_d;
    logic [OUT_WIDTH-1:0]         yi_d, yq_d;
    logic [2*OUT_WIDTH-1:0]       pdata_d, pdata_q;
    logic                         out_tvalid_q, out_tlast_q;

    // Whole pipe moves as one; in_tready never looks at in_tvalid.
    assign adv        = ~out_tvalid_q | out_tready;
    assign in_tready  = adv;
    assign out_tvalid = out_tvalid_q;
    assign out_tlast  = out_tlast_q;
    assign pdata      = pdata_q;

    assign rr_x = {rr_q[PW-1], rr_q};
    assign ii_x = {ii_q[PW-1], ii_q};
    assign ri_x = {ri_q[PW-1], ri_q};
    assign ir_x = {ir_q[PW-1], ir_q};

    always_comb begin
        if (s2_conj_q) begin
            i_d = rr_x + ii_x;
            q_d = ir_x - ri_x;
        end else begin
            i_d = rr_x - ii_x;
            q_d = ri_x + ir_x;
        end
    end

    always_comb begin
        pdata_d = '0;
        pdata_d[P_I_LO +: OUT_WIDTH] = yi_d;
        pdata_d[P_Q_LO +: OUT_WIDTH] = yq_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q       <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_conj_q    <= 1'b0;
            ar_q         <= '0;
            ai_q         <= '0;
            br_q         <= '0;
            bi_q         <= '0;
            s2_v_q       <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_conj_q    <= 1'b0;
            rr_q         <= '0;
            ii_q         <= '0;
            ri_q         <= '0;
            ir_q         <= '0;
            s3_v_q       <= 1'b0;
            s3_last_q    <= 1'b0;
            i_q          <= '0;
            q_q          <= '0;
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
            pdata_q      <= '0;
        end else if (adv) begin
            s1_v_q       <= in_tvalid;
            s1_last_q    <= in_tlast;
            s1_conj_q    <= in_tconj;
            ar_q         <= adata[A_I_LO +: DATA_WIDTH];
            ai_q         <= adata[A_Q_LO +: DATA_WIDTH];
            br_q         <= bdata[A_I_LO +: DATA_WIDTH];
            bi_q         <= bdata[A_Q_LO +: DATA_WIDTH];
            s2_v_q       <= s1_v_q;
            s2_last_q    <= s1_last_q;
            s2_conj_q    <= s1_conj_q;
            rr_q         <= PW'(ar_q) * PW'(br_q);
            ii_q         <= PW'(ai_q) * PW'(bi_q);
            ri_q         <= PW'(ar_q) * PW'(bi_q);
            ir_q         <= PW'(ai_q) * PW'(br_q);
            s3_v_q       <= s2_v_q;
            s3_last_q    <= s2_last_q;
            i_q          <= i_d;
            q_q          <= q_d;
            out_tvalid_q <= s3_v_q;
            out_tlast_q  <= s3_last_q;
            pdata_q      <= pdata_d;
        end
    end

`ifdef CMUL_RND_SAT_FLAG_EN
    logic sat_i_d, sat_q_d, out_tsat_q, sat_sticky_q;

    rnd_sat_stage #(.IN_WIDTH(FW), .OUT_WIDTH(OUT_WIDTH), .CLIP_BITS(CLIP_BITS))
        u_rnd_i (.x_i(i_q), .y_o(yi_d), .sat_o(sat_i_d));
    rnd_sat_stage #(.IN_WIDTH(FW), .OUT_WIDTH(OUT_WIDTH), .CLIP_BITS(CLIP_BITS))
        u_rnd_q (.x_i(q_q), .y_o(yq_d), .sat_o(sat_q_d));

    // Sticky only records clamped beats that actually leave the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_tsat_q   <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            if (adv) begin
                out_tsat_q <= sat_i_d | sat_q_d;
            end
            if (out_tvalid_q && out_tready && out_tsat_q) begin
                sat_sticky_q <= 1'b1;
            end
        end
    end

    assign out_tsat   = out_tsat_q;
    assign sat_sticky = sat_sticky_q;
`else
    rnd_sat_stage #(.IN_WIDTH(FW), .OUT_WIDTH(OUT_WIDTH), .CLIP_BITS(CLIP_BITS))
        u_rnd_i (.x_i(i_q), .y_o(yi_d));
    rnd_sat_stage #(.IN_WIDTH(FW), .OUT_WIDTH(OUT_WIDTH), .CLIP_BITS(CLIP_BITS))
        u_rnd_q (.x_i(q_q), .y_o(yq_d));
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmul_rnd_sat_pipe.sv
// ============================================================================
// Module      : tb_cmul_rnd_sat_pipe
// Description : Scoreboard bench for cmul_rnd_sat_pipe (default and
//               CLIP_BITS=1 instances); CMUL_RND_SAT_FLAG_EN adds flag checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmul_rnd_sat_pipe;

    localparam int DW = 16;
    localparam int OW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_tvalid = 1'b0, in_tlast = 1'b0, in_tconj = 1'b0, out_tready = 1'b0;
    logic [31:0] adata = '0, bdata = '0;
    logic        in_tready, out_tvalid, out_tlast;
    logic [31:0] pdata;

    logic        c_in_tvalid = 1'b0, c_in_tlast = 1'b0, c_in_tconj = 1'b0;
    logic [31:0] c_adata = '0, c_bdata = '0;
    logic        c_in_tready, c_out_tvalid, c_out_tlast;
    logic [31:0] c_pdata;

`ifdef CMUL_RND_SAT_FLAG_EN
    logic out_tsat, sat_sticky, c_out_tsat, c_sat_sticky;
`endif

    always #5 clk = ~clk;

    cmul_rnd_sat_pipe dut (
        .clk(clk), .reset(reset),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast), .in_tconj(in_tconj),
        .adata(adata), .bdata(bdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast), .pdata(pdata)
`ifdef CMUL_RND_SAT_FLAG_EN
        , .out_tsat(out_tsat), .sat_sticky(sat_sticky)
`endif
    );

    cmul_rnd_sat_pipe #(.DATA_WIDTH(16), .OUT_WIDTH(16), .CLIP_BITS(1)) dut_clip (
        .clk(clk), .reset(reset),
        .in_tvalid(c_in_tvalid), .in_tready(c_in_tready), .in_tlast(c_in_tlast), .in_tconj(c_in_tconj),
        .adata(c_adata), .bdata(c_bdata),
        .out_tvalid(c_out_tvalid), .out_tready(1'b1), .out_tlast(c_out_tlast), .pdata(c_pdata)
`ifdef CMUL_RND_SAT_FLAG_EN
        , .out_tsat(c_out_tsat), .sat_sticky(c_sat_sticky)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [33:0] exp_q[$];       // {sat, last, pdata}
    logic [32:0] got_q[$];       // {last, pdata}
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact complex product, round half up, clamp to OW bits.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic conj, input int cb);
        longint ar, ai, br, bi, i, q, hi, lo;
        int     drop;
        logic   sat;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        if (conj) begin
            i = ar * br + ai * bi;
            q = ai * br - ar * bi;
        end else begin
            i = ar * br - ai * bi;
            q = ar * bi + ai * br;
        end
        drop = 2 * DW + 1 - OW - cb;
        if (drop > 0) begin
            i = (i + (64'sd1 <<< (drop - 1))) >>> drop;
            q = (q + (64'sd1 <<< (drop - 1))) >>> drop;
        end
        hi  = (64'sd1 <<< (OW - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
        if (i > hi) begin i = hi; sat = 1'b1; end
        if (i < lo) begin i = lo; sat = 1'b1; end
        if (q > hi) begin q = hi; sat = 1'b1; end
        if (q < lo) begin q = lo; sat = 1'b1; end
        return {sat, i[15:0], q[15:0]};
    endfunction

    // One clock of the main DUT: drive at negedge, observe handshakes 1ns later.
    task automatic step(input logic rst, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic last, input logic conj, input logic rdy);
        logic [33:0] e, cur;
        logic [32:0] m;
        @(negedge clk);
        reset = rst; in_tvalid = v; adata = a; bdata = b;
        in_tlast = last; in_tconj = conj; out_tready = rdy;
        #1;
        cur = {out_tvalid, out_tlast, pdata};
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_tready", in_tready, !out_tvalid || out_tready);
            if (prev_stall) chk("stall_stable", cur, prev_out);
            if (out_tvalid && out_tready) begin
                got_q.push_back({out_tlast, pdata});
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pdata", pdata, e[31:0]);
                    chk("sb_tlast", out_tlast, e[32]);
`ifdef CMUL_RND_SAT_FLAG_EN
                    chk("sb_tsat", out_tsat, e[33]);
`endif
                end
            end
            if (in_tvalid && in_tready) begin
                m = model(a, b, conj, 0);
                exp_q.push_back({m[32], last, m[31:0]});
            end
            prev_stall = out_tvalid && !out_tready;
            prev_out   = cur;
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
    endtask

    // Single beat, checks it lands exactly on the 4th cycle after acceptance.
    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic conj, input logic [31:0] exp_pd);
        logic [32:0] g;
        got_q.delete();
        step(1'b0, 1'b1, a, b, 1'b0, conj, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            idle(1'b1);
            if (k == 3) chk({tag, "_early"}, out_tvalid, 1'b0);
            if (k == 4) chk({tag, "_lat"}, out_tvalid, 1'b1);
        end
        chk({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            chk(tag, g[31:0], exp_pd);
        end
        got_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] g;
        logic [31:0] ra, rb;
        logic        rv, rr, rc, rl;
        int          sent, guard, k;

        repeat (3) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("rst_tvalid", out_tvalid, 1'b0);
        chk("rst_tlast", out_tlast, 1'b0);
        chk("rst_pdata", pdata, 32'h0);
        chk("rst_tready", in_tready, 1'b1);
`ifdef CMUL_RND_SAT_FLAG_EN
        chk("rst_sticky", sat_sticky, 1'b0);
`endif

        directed("unity", {16'd16384, 16'd0}, {16'd16384, 16'd0}, 1'b0, {16'd2048, 16'd0});
        directed("half_up", {16'd256, 16'd0}, {16'd256, 16'd0}, 1'b0, {16'd1, 16'd0});
        directed("half_neg", {16'd256, 16'd0}, {16'hFF00, 16'd0}, 1'b0, {16'd0, 16'd0});

        // Back-to-back: a*b then a*conj(b), tlast on second beat only.
        got_q.delete();
        step(1'b0, 1'b1, {16'd0, 16'd1000}, {16'd0, 16'd1000}, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, {16'd0, 16'd1000}, {16'd0, 16'd1000}, 1'b1, 1'b1, 1'b1);
        repeat (5) idle(1'b1);
        chk("b2b_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            g = got_q.pop_front();
            chk("b2b_first", g, {1'b0, 16'hFFF8, 16'h0000});
            g = got_q.pop_front();
            chk("b2b_second", g, {1'b1, 16'h0008, 16'h0000});
        end
        got_q.delete();

        // Saturation on the CLIP_BITS=1 instance: 2^31 >> 16 clamps to 32767.
        @(negedge clk);
        c_in_tvalid = 1'b1; c_in_tlast = 1'b1; c_in_tconj = 1'b1;
        c_adata = {16'h8000, 16'h8000}; c_bdata = {16'h8000, 16'h8000};
        @(negedge clk);
        c_in_tvalid = 1'b0; c_in_tlast = 1'b0;
        #1;
        k = 1;
        while (!c_out_tvalid && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("clip_lat", k, 4);
        chk("clip_pdata", c_pdata, {16'h7FFF, 16'h0000});
        chk("clip_tlast", c_out_tlast, 1'b1);
`ifdef CMUL_RND_SAT_FLAG_EN
        chk("clip_tsat", c_out_tsat, 1'b1);
        @(negedge clk);
        #1;
        chk("clip_sticky", c_sat_sticky, 1'b1);
`endif

        // Random traffic with 50% downstream backpressure.
        sent  = 0;
        guard = 0;
        while (sent < 1000 && guard < 6000) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = $urandom_range(0, 1);
            rc = $urandom_range(0, 1);
            rl = ($urandom_range(0, 7) == 0);
            ra = $urandom;
            rb = $urandom;
            step(1'b0, rv, ra, rb, rl, rc, rr);
            if (in_tvalid && in_tready) sent++;
            guard++;
        end
        chk("rand_sent", sent, 1000);
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            idle(1'b1);
            guard++;
        end
        chk("drain_left", exp_q.size(), 0);

        // Reset with three beats in flight: nothing may emerge afterwards.
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 32'h12345678, 32'h0ABC0DEF, 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 1'b1, 32'h11112222, 32'h33334444, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("rst_flush_valid", out_tvalid, 1'b0);
        for (int n = 0; n < 8; n++) begin
            idle(1'b1);
            chk("no_stale", out_tvalid, 1'b0);
        end
`ifdef CMUL_RND_SAT_FLAG_EN
        chk("main_sticky", sat_sticky, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
